// File: rtl/motor_phase_decoder_if.sv
// motor_phase_decoder_if: phase-line observation and step/position telemetry bundle
interface motor_phase_decoder_if #(
    parameter int POS_W = 16,
    parameter int PER_W = 16
);
    logic [3:0] F;
    logic clr;
    logic step;
    logic dir;
    logic [POS_W-1:0] pos;
    logic [PER_W-1:0] period;
    logic period_valid;
    logic stalled;
    logic fault;
    logic phase_ok;
    modport master (output F, clr, input step, dir, pos, period, period_valid, stalled, fault, phase_ok);
    modport slave (input F, clr, output step, dir, pos, period, period_valid, stalled, fault, phase_ok);
endinterface

// File: rtl/motor_phase_decoder.sv
// motor_phase_decoder: turns observed 4-phase stepper patterns into step, direction, position, period, stall and fault telemetry
module motor_phase_decoder #(
    parameter int POS_W = 16,
    parameter int PER_W = 16,
    parameter int FILT = 2,
    parameter int STALL_CYCLES = 1000
) (
    input logic CLK,
    input logic RST_N,
    motor_phase_decoder_if.slave bus
);
    localparam logic [0:0] ACQ = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;
    localparam logic [3:0] FL = 4'(FILT);
    localparam logic [PER_W-1:0] ST = PER_W'(STALL_CYCLES - 1);
    localparam logic [PER_W-1:0] MX = '1;

    function automatic logic [2:0] dec(input logic [3:0] p);
        return p == 4'b0011 ? 3'b100 : p == 4'b0110 ? 3'b101 : p == 4'b1100 ? 3'b110 : p == 4'b1001 ? 3'b111 : 3'b000;
    endfunction

    logic [3:0] s1, s2, cand, fp, cnt, cnt_n;
    logic [0:0] st;
    logic [1:0] idx, d;
    logic [2:0] dc;
    logic [PER_W-1:0] ic, ic_n;
    logic upd, trk, acq, fwd, rev, skp, ill, stp, fev, got;

    // filter qualification of s2 and classification of the new pattern against the tracked index
    always_comb begin
        cnt_n = s2 != cand ? 4'd1 : cnt == FL ? cnt : cnt + 4'd1;
        upd = cnt_n == FL && s2 != fp;
        dc = dec(s2);
        d = dc[1:0] - idx;
        trk = upd && st == TRACK;
        acq = upd && st == ACQ && dc[2];
        fwd = trk && dc[2] && d == 2'd1;
        rev = trk && dc[2] && d == 2'd3;
        skp = trk && dc[2] && d == 2'd2;
        ill = trk && !dc[2];
        stp = fwd || rev;
        fev = skp || ill;
        ic_n = st != TRACK || stp || ill ? '0 : ic == MX ? ic : ic + PER_W'(1);
    end

    // two-stage synchronizer for the asynchronous phase lines
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.F;
            s2 <= s1;
        end
    end

    // glitch filter: s2 must stay put for FILT edges before it becomes the accepted pattern
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cand <= '0;
            cnt <= '0;
            fp <= '0;
        end else begin
            cand <= s2;
            cnt <= cnt_n;
            if (upd) fp <= s2;
        end
    end

    // acquire/track sequencing, position, period measurement, stall and fault flags
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st <= ACQ;
            idx <= '0;
            ic <= '0;
            got <= 1'b0;
            bus.step <= 1'b0;
            bus.dir <= 1'b1;
            bus.pos <= '0;
            bus.period <= '0;
            bus.period_valid <= 1'b0;
            bus.stalled <= 1'b0;
            bus.fault <= 1'b0;
            bus.phase_ok <= 1'b0;
        end else begin
            st <= ill ? ACQ : acq ? TRACK : st;
            if (upd && dc[2]) idx <= dc[1:0];
            ic <= ic_n;
            got <= fev ? 1'b0 : stp ? 1'b1 : got;
            bus.step <= stp;
            if (stp) bus.dir <= fwd;
            bus.pos <= bus.clr ? '0 : fwd ? bus.pos + POS_W'(1) : rev ? bus.pos - POS_W'(1) : bus.pos;
            if (stp) bus.period <= ic == MX ? MX : ic + PER_W'(1);
            bus.period_valid <= fev ? 1'b0 : stp ? got : bus.period_valid;
            bus.stalled <= st == TRACK && !stp && !ill && (ic_n == ST || bus.stalled);
            bus.fault <= fev || (bus.fault && !bus.clr);
            bus.phase_ok <= upd ? dc[2] : bus.phase_ok;
        end
    end
endmodule

// File: tb/tb_motor_phase_decoder.sv
// tb_motor_phase_decoder: directed scenario checks of the stepper phase decoder
module tb_motor_phase_decoder;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int total = 0;
    int bad = 0;
    int nstep = 0;
    int n0;

    motor_phase_decoder_if #(.POS_W(16), .PER_W(16)) bus();
    motor_phase_decoder #(.POS_W(16), .PER_W(16), .FILT(2), .STALL_CYCLES(1000)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus.slave));

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (bus.step === 1'b1) nstep++;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic hold(input logic [3:0] p, input int n);
        bus.F = p;
        tick(n);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        bus.F = 4'b0000;
        bus.clr = 1'b0;
        tick(2);
        RST_N = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL rst_step got=%0h exp=0", bus.step); end
        total++; if (bus.dir !== 1'b1) begin bad++; $display("FAIL rst_dir got=%0h exp=1", bus.dir); end
        total++; if (bus.pos !== 16'h0000) begin bad++; $display("FAIL rst_pos got=%0h exp=0", bus.pos); end
        total++; if (bus.period !== 16'h0000) begin bad++; $display("FAIL rst_period got=%0h exp=0", bus.period); end
        total++; if (bus.period_valid !== 1'b0) begin bad++; $display("FAIL rst_pv got=%0h exp=0", bus.period_valid); end
        total++; if (bus.stalled !== 1'b0) begin bad++; $display("FAIL rst_stalled got=%0h exp=0", bus.stalled); end
        total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%0h exp=0", bus.fault); end
        total++; if (bus.phase_ok !== 1'b0) begin bad++; $display("FAIL rst_phase_ok got=%0h exp=0", bus.phase_ok); end
    endtask

    task automatic test_forward();
        do_reset();
        n0 = nstep;
        hold(4'b0011, 10);
        total++; if (nstep - n0 !== 0) begin bad++; $display("FAIL fwd_acq_steps got=%0d exp=0", nstep - n0); end
        hold(4'b0110, 10);
        hold(4'b1100, 10);
        hold(4'b1001, 10);
        hold(4'b0011, 10);
        total++; if (nstep - n0 !== 4) begin bad++; $display("FAIL fwd_steps got=%0d exp=4", nstep - n0); end
        total++; if (bus.pos !== 16'd4) begin bad++; $display("FAIL fwd_pos got=%0h exp=4", bus.pos); end
        total++; if (bus.dir !== 1'b1) begin bad++; $display("FAIL fwd_dir got=%0h exp=1", bus.dir); end
        total++; if (bus.period !== 16'd10) begin bad++; $display("FAIL fwd_period got=%0d exp=10", bus.period); end
        total++; if (bus.period_valid !== 1'b1) begin bad++; $display("FAIL fwd_pv got=%0h exp=1", bus.period_valid); end
        total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL fwd_fault got=%0h exp=0", bus.fault); end
        total++; if (bus.phase_ok !== 1'b1) begin bad++; $display("FAIL fwd_phase_ok got=%0h exp=1", bus.phase_ok); end
    endtask

    task automatic test_reverse_wrap();
        do_reset();
        hold(4'b0011, 10);
        hold(4'b1001, 3);
        total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL rev_early_step got=%0h exp=0", bus.step); end
        tick(1);
        total++; if (bus.step !== 1'b1) begin bad++; $display("FAIL rev_latency_step got=%0h exp=1", bus.step); end
        tick(1);
        total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL rev_pulse_width got=%0h exp=0", bus.step); end
        tick(5);
        total++; if (bus.pos !== 16'hFFFF) begin bad++; $display("FAIL rev_pos got=%0h exp=ffff", bus.pos); end
        total++; if (bus.dir !== 1'b0) begin bad++; $display("FAIL rev_dir got=%0h exp=0", bus.dir); end
        hold(4'b0011, 10);
        total++; if (bus.pos !== 16'h0000) begin bad++; $display("FAIL wrap_pos got=%0h exp=0", bus.pos); end
        total++; if (bus.dir !== 1'b1) begin bad++; $display("FAIL wrap_dir got=%0h exp=1", bus.dir); end
    endtask

    task automatic test_glitch();
        do_reset();
        hold(4'b0011, 10);
        n0 = nstep;
        hold(4'b0110, 1);
        hold(4'b0011, 10);
        total++; if (nstep - n0 !== 0) begin bad++; $display("FAIL glitch_steps got=%0d exp=0", nstep - n0); end
        total++; if (bus.pos !== 16'h0000) begin bad++; $display("FAIL glitch_pos got=%0h exp=0", bus.pos); end
        total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL glitch_fault got=%0h exp=0", bus.fault); end
    endtask

    task automatic test_skip_illegal();
        do_reset();
        hold(4'b0011, 10);
        n0 = nstep;
        hold(4'b1100, 10);
        total++; if (bus.fault !== 1'b1) begin bad++; $display("FAIL skip_fault got=%0h exp=1", bus.fault); end
        total++; if (bus.pos !== 16'h0000) begin bad++; $display("FAIL skip_pos got=%0h exp=0", bus.pos); end
        total++; if (nstep - n0 !== 0) begin bad++; $display("FAIL skip_steps got=%0d exp=0", nstep - n0); end
        hold(4'b1001, 10);
        total++; if (nstep - n0 !== 1) begin bad++; $display("FAIL after_skip_steps got=%0d exp=1", nstep - n0); end
        total++; if (bus.pos !== 16'd1) begin bad++; $display("FAIL after_skip_pos got=%0h exp=1", bus.pos); end
        hold(4'b0000, 10);
        total++; if (bus.phase_ok !== 1'b0) begin bad++; $display("FAIL illegal_phase_ok got=%0h exp=0", bus.phase_ok); end
        hold(4'b0110, 10);
        total++; if (nstep - n0 !== 1) begin bad++; $display("FAIL reacq_steps got=%0d exp=1", nstep - n0); end
        total++; if (bus.phase_ok !== 1'b1) begin bad++; $display("FAIL reacq_phase_ok got=%0h exp=1", bus.phase_ok); end
        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
        total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL clr_fault got=%0h exp=0", bus.fault); end
        total++; if (bus.pos !== 16'h0000) begin bad++; $display("FAIL clr_pos got=%0h exp=0", bus.pos); end
        hold(4'b1100, 10);
        total++; if (bus.pos !== 16'd1) begin bad++; $display("FAIL post_clr_pos got=%0h exp=1", bus.pos); end
        hold(4'b1001, 3);
        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
        total++; if (bus.step !== 1'b1) begin bad++; $display("FAIL clr_step_pulse got=%0h exp=1", bus.step); end
        total++; if (bus.pos !== 16'h0000) begin bad++; $display("FAIL clr_step_pos got=%0h exp=0", bus.pos); end
        tick(6);
        hold(4'b0110, 3);
        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
        tick(1);
        total++; if (bus.fault !== 1'b1) begin bad++; $display("FAIL clr_vs_fault got=%0h exp=1", bus.fault); end
    endtask

    task automatic test_stall();
        do_reset();
        hold(4'b0011, 10);
        hold(4'b0110, 4);
        total++; if (bus.step !== 1'b1) begin bad++; $display("FAIL stall_first_step got=%0h exp=1", bus.step); end
        tick(998);
        total++; if (bus.stalled !== 1'b0) begin bad++; $display("FAIL stall_early got=%0h exp=0", bus.stalled); end
        tick(2);
        total++; if (bus.stalled !== 1'b1) begin bad++; $display("FAIL stall_set got=%0h exp=1", bus.stalled); end
        tick(196);
        hold(4'b1100, 4);
        total++; if (bus.stalled !== 1'b0) begin bad++; $display("FAIL stall_clear got=%0h exp=0", bus.stalled); end
        total++; if (bus.period !== 16'd1200) begin bad++; $display("FAIL stall_period got=%0d exp=1200", bus.period); end
        total++; if (bus.period_valid !== 1'b1) begin bad++; $display("FAIL stall_pv got=%0h exp=1", bus.period_valid); end
        hold(4'b1001, 70000);
        hold(4'b0011, 4);
        total++; if (bus.period !== 16'hFFFF) begin bad++; $display("FAIL sat_period got=%0h exp=ffff", bus.period); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        hold(4'b0011, 10);
        hold(4'b0110, 10);
        hold(4'b1100, 3);
        RST_N = 1'b0;
        #1;
        total++; if (bus.pos !== 16'h0000) begin bad++; $display("FAIL mid_pos got=%0h exp=0", bus.pos); end
        total++; if (bus.dir !== 1'b1) begin bad++; $display("FAIL mid_dir got=%0h exp=1", bus.dir); end
        total++; if (bus.period !== 16'h0000) begin bad++; $display("FAIL mid_period got=%0h exp=0", bus.period); end
        total++; if (bus.phase_ok !== 1'b0) begin bad++; $display("FAIL mid_phase_ok got=%0h exp=0", bus.phase_ok); end
        total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL mid_step got=%0h exp=0", bus.step); end
        tick(1);
        RST_N = 1'b1;
        n0 = nstep;
        tick(10);
        total++; if (nstep - n0 !== 0) begin bad++; $display("FAIL mid_reacq_steps got=%0d exp=0", nstep - n0); end
        total++; if (bus.phase_ok !== 1'b1) begin bad++; $display("FAIL mid_reacq_phase_ok got=%0h exp=1", bus.phase_ok); end
        hold(4'b1001, 10);
        total++; if (bus.pos !== 16'd1) begin bad++; $display("FAIL mid_track_pos got=%0h exp=1", bus.pos); end
    endtask

    initial begin
        bus.F = 4'b0000;
        bus.clr = 1'b0;
        test_reset();
        test_forward();
        test_reverse_wrap();
        test_glitch();
        test_skip_illegal();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
